hyperbus_ctrl: RTL and testbench



---
 rtl/hyperbus_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_hyperbus_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperbus_ctrl.sv
// HyperBus transaction controller: turns native word requests into
// CA / latency / data phases on an 8-bit HyperBus PHY, one byte per clock.
module hyperbus_ctrl #(
    parameter int LATENCY    = 6,
    parameter int RECOVERY   = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic        hbus_clk,
    input  logic        hbus_rst_n,
    input  logic [31:0] hbus_adr_i,
    input  logic [15:0] hbus_dat_i,
    output logic [15:0] hbus_dat_o,
    input  logic        hbus_rrq,
    input  logic        hbus_wrq,
    output logic        hbus_ready,
    output logic        hbus_valid,
    output logic        hbus_busy,
    output logic        hbus_cs_n_o,
    output logic        hbus_ck_o,
    output logic [7:0]  hbus_dq_o,
    output logic        hbus_dq_oe,
    input  logic [7:0]  hbus_dq_i,
    output logic        hbus_rwds_o,
    output logic        hbus_rwds_oe,
    input  logic        hbus_rwds_i
);

    localparam int CW = $clog2(4*LATENCY + RECOVERY + 8);
    localparam logic [CW-1:0] CA_LAST  = CW'(5);
    localparam logic [CW-1:0] LAT_LAST = CW'(4*LATENCY - 1);
    localparam logic [CW-1:0] LAT_PRE  = CW'(4*LATENCY - 2);
    localparam logic [CW-1:0] REC_LAST = CW'(RECOVERY - 1);
    localparam int TW = $clog2(RD_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_WDATA, S_RDATA, S_END} state_t;

    state_t        state_q, state_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic [47:0]   ca_q, ca_nxt, ca_w;
    logic [7:0]    wlo_q, wlo_nxt;
    logic [7:0]    rhi_q, rhi_nxt;
    logic          have_hi_q, have_hi_nxt;
    logic          stop_q, stop_nxt;
    logic          rd_q, rd_nxt;
    logic [TW-1:0] to_q, to_nxt;
    logic          go_end;

    logic          cs_n_nxt, ck_nxt, dq_oe_nxt, rwds_oe_nxt;
    logic          ready_nxt, valid_nxt, busy_nxt;
    logic [7:0]    dq_nxt;
    logic [15:0]   dat_o_nxt;

    // RWDS is only driven during writes and never masks a byte.
    assign hbus_rwds_o = 1'b0;

    // State, counters and every PHY/native output are registered here.
    always_ff @(posedge hbus_clk or negedge hbus_rst_n) begin
        if (!hbus_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ca_q         <= '0;
            wlo_q        <= '0;
            rhi_q        <= '0;
            have_hi_q    <= 1'b0;
            stop_q       <= 1'b0;
            rd_q         <= 1'b0;
            to_q         <= '0;
            hbus_cs_n_o  <= 1'b1;
            hbus_ck_o    <= 1'b0;
            hbus_dq_o    <= 8'h00;
            hbus_dq_oe   <= 1'b0;
            hbus_rwds_oe <= 1'b0;
            hbus_ready   <= 1'b0;
            hbus_valid   <= 1'b0;
            hbus_busy    <= 1'b0;
            hbus_dat_o   <= 16'h0000;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            ca_q         <= ca_nxt;
            wlo_q        <= wlo_nxt;
            rhi_q        <= rhi_nxt;
            have_hi_q    <= have_hi_nxt;
            stop_q       <= stop_nxt;
            rd_q         <= rd_nxt;
            to_q         <= to_nxt;
            hbus_cs_n_o  <= cs_n_nxt;
            hbus_ck_o    <= ck_nxt;
            hbus_dq_o    <= dq_nxt;
            hbus_dq_oe   <= dq_oe_nxt;
            hbus_rwds_oe <= rwds_oe_nxt;
            hbus_ready   <= ready_nxt;
            hbus_valid   <= valid_nxt;
            hbus_busy    <= busy_nxt;
            hbus_dat_o   <= dat_o_nxt;
        end
    end

    // Next state plus the output values for the following cycle; a read that
    // must stop on an odd CS-low cycle spends one padding cycle so CS always
    // stays low for an even count.
    always_comb begin
        state_nxt   = state_q;
        cnt_nxt     = cnt_q;
        ca_nxt      = ca_q;
        ca_w        = '0;
        wlo_nxt     = wlo_q;
        rhi_nxt     = rhi_q;
        have_hi_nxt = have_hi_q;
        stop_nxt    = stop_q;
        rd_nxt      = rd_q;
        to_nxt      = to_q;
        go_end      = 1'b0;
        cs_n_nxt    = hbus_cs_n_o;
        ck_nxt      = 1'b0;
        dq_nxt      = 8'h00;
        dq_oe_nxt   = 1'b0;
        rwds_oe_nxt = 1'b0;
        ready_nxt   = 1'b0;
        valid_nxt   = 1'b0;
        busy_nxt    = hbus_busy;
        dat_o_nxt   = hbus_dat_o;

        case (state_q)
            S_IDLE: begin
                if (hbus_rrq || hbus_wrq) begin
                    rd_nxt    = hbus_rrq;
                    ca_w      = {hbus_rrq, 1'b0, 1'b1, hbus_adr_i[31:3], 13'd0, hbus_adr_i[2:0]};
                    dq_nxt    = ca_w[47:40];
                    ca_nxt    = {ca_w[39:0], 8'h00};
                    state_nxt = S_CA;
                    cnt_nxt   = '0;
                    cs_n_nxt  = 1'b0;
                    dq_oe_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            S_CA: begin
                ck_nxt = ~hbus_ck_o;
                if (cnt_q == CA_LAST) begin
                    state_nxt = S_LAT;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_q + CW'(1);
                    dq_nxt    = ca_q[47:40];
                    ca_nxt    = {ca_q[39:0], 8'h00};
                    dq_oe_nxt = 1'b1;
                end
            end
            S_LAT: begin
                ck_nxt = ~hbus_ck_o;
                if (cnt_q == LAT_LAST) begin
                    if (rd_q) begin
                        state_nxt   = S_RDATA;
                        have_hi_nxt = 1'b0;
                        stop_nxt    = 1'b0;
                        to_nxt      = '0;
                    end else begin
                        state_nxt   = S_WDATA;
                        cnt_nxt     = '0;
                        dq_nxt      = hbus_dat_i[15:8];
                        wlo_nxt     = hbus_dat_i[7:0];
                        dq_oe_nxt   = 1'b1;
                        rwds_oe_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                    if (cnt_q == LAT_PRE && !rd_q) begin
                        ready_nxt = 1'b1;
                    end
                end
            end
            S_WDATA: begin
                ck_nxt = ~hbus_ck_o;
                if (!cnt_q[0]) begin
                    cnt_nxt     = CW'(1);
                    dq_nxt      = wlo_q;
                    dq_oe_nxt   = 1'b1;
                    rwds_oe_nxt = 1'b1;
                    ready_nxt   = hbus_wrq;
                end else if (hbus_ready) begin
                    cnt_nxt     = '0;
                    dq_nxt      = hbus_dat_i[15:8];
                    wlo_nxt     = hbus_dat_i[7:0];
                    dq_oe_nxt   = 1'b1;
                    rwds_oe_nxt = 1'b1;
                end else begin
                    go_end = 1'b1;
                end
            end
            S_RDATA: begin
                ck_nxt = ~hbus_ck_o;
                if (stop_q) begin
                    go_end = 1'b1;
                end else if (!hbus_rrq || (!hbus_rwds_i && to_q == TO_LAST)) begin
                    if (hbus_ck_o) begin
                        go_end = 1'b1;
                    end else begin
                        stop_nxt = 1'b1;
                    end
                end else if (hbus_rwds_i) begin
                    to_nxt = '0;
                    if (have_hi_q) begin
                        dat_o_nxt   = {rhi_q, hbus_dq_i};
                        valid_nxt   = 1'b1;
                        have_hi_nxt = 1'b0;
                    end else begin
                        rhi_nxt     = hbus_dq_i;
                        have_hi_nxt = 1'b1;
                    end
                end else begin
                    to_nxt = to_q + TW'(1);
                end
            end
            S_END: begin
                cs_n_nxt = 1'b1;
                if (cnt_q == REC_LAST) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (go_end) begin
            state_nxt   = S_END;
            cnt_nxt     = '0;
            cs_n_nxt    = 1'b1;
            ck_nxt      = 1'b0;
            dq_nxt      = 8'h00;
            dq_oe_nxt   = 1'b0;
            rwds_oe_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Bench for hyperbus_ctrl: table of directed transactions, hand-built corner
// sequences, then random transactions checked cycle by cycle against a
// transaction-level model of the bus timing.
module tb_hyperbus_ctrl;

    localparam int LATENCY    = 6;
    localparam int RECOVERY   = 4;
    localparam int RD_TIMEOUT = 255;
    localparam int LAT_END    = 6 + 4*LATENCY;
    localparam int MAXC       = 640;
    localparam int NEVER      = 100000;

    logic        hbus_clk = 1'b0;
    logic        hbus_rst_n = 1'b0;
    logic [31:0] hbus_adr_i = '0;
    logic [15:0] hbus_dat_i = '0;
    logic [15:0] hbus_dat_o;
    logic        hbus_rrq = 1'b0;
    logic        hbus_wrq = 1'b0;
    logic        hbus_ready, hbus_valid, hbus_busy;
    logic        hbus_cs_n_o, hbus_ck_o;
    logic [7:0]  hbus_dq_o;
    logic        hbus_dq_oe;
    logic [7:0]  hbus_dq_i = '0;
    logic        hbus_rwds_o, hbus_rwds_oe;
    logic        hbus_rwds_i = 1'b0;

    hyperbus_ctrl #(.LATENCY(LATENCY), .RECOVERY(RECOVERY), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .hbus_clk(hbus_clk), .hbus_rst_n(hbus_rst_n),
        .hbus_adr_i(hbus_adr_i), .hbus_dat_i(hbus_dat_i), .hbus_dat_o(hbus_dat_o),
        .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid), .hbus_busy(hbus_busy),
        .hbus_cs_n_o(hbus_cs_n_o), .hbus_ck_o(hbus_ck_o),
        .hbus_dq_o(hbus_dq_o), .hbus_dq_oe(hbus_dq_oe), .hbus_dq_i(hbus_dq_i),
        .hbus_rwds_o(hbus_rwds_o), .hbus_rwds_oe(hbus_rwds_oe), .hbus_rwds_i(hbus_rwds_i)
    );

    // Free-running controller clock.
    always #5 hbus_clk = ~hbus_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Current transaction description.
    logic        tr_rd, tr_both, tr_hold;
    logic [31:0] tr_adr;
    int          tr_nwords, tr_drop, tr_abort;
    logic [15:0] tr_words[8];
    bit          tr_rwds[MAXC];
    logic [7:0]  tr_byte[MAXC];

    // Expected behaviour built by the model, and observations.
    bit          exp_ready[MAXC];
    bit          exp_valid[MAXC];
    logic [7:0]  exp_dq[MAXC];
    logic [15:0] exp_dat[MAXC];
    int          last_low;
    logic [47:0] obs_ca;
    logic [15:0] obs_wdat, obs_dat;
    int          obs_nvalid, obs_cs_low;

    typedef struct {
        logic        rd;
        logic        both;
        logic [31:0] adr;
        logic [15:0] data;
        logic [47:0] exp_ca;
    } vec_t;
    vec_t vecs[6];

    // Safety net so the run can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [47:0] caOf(input logic rd, input logic [31:0] adr);
        return {rd, 1'b0, 1'b1, adr[31:3], 13'd0, adr[2:0]};
    endfunction

    task automatic setDefaults();
        tr_both = 1'b0; tr_hold = 1'b0; tr_abort = -1; tr_drop = NEVER; tr_nwords = 1;
        for (int i = 0; i < MAXC; i++) begin
            tr_rwds[i] = 1'b0;
            tr_byte[i] = 8'($urandom);
        end
    endtask

    // Transaction-level model: derives ready/valid/data timing and the
    // length of the CS-low window from the protocol rules.
    task automatic buildModel();
        logic [47:0] ca;
        logic [7:0]  hi;
        bit          have;
        int          idle, term, t;
        for (int c = 0; c < MAXC; c++) begin
            exp_ready[c] = 0; exp_valid[c] = 0; exp_dq[c] = 8'h00; exp_dat[c] = 16'h0000;
        end
        ca = caOf(tr_rd, tr_adr);
        for (int b = 0; b < 6; b++) exp_dq[1+b] = ca[47-8*b -: 8];
        if (!tr_rd) begin
            for (int k = 0; k < tr_nwords; k++) begin
                exp_ready[LAT_END+2*k] = 1;
                exp_dq[LAT_END+1+2*k]  = tr_words[k][15:8];
                exp_dq[LAT_END+2+2*k]  = tr_words[k][7:0];
            end
            last_low = LAT_END + 2*tr_nwords;
        end else begin
            have = 0; hi = 8'h00; idle = 0; term = -1;
            for (int i = 0; term < 0 && i < MAXC - 64; i++) begin
                if (i >= tr_drop) term = i;
                else if (tr_rwds[i]) begin
                    idle = 0;
                    if (have) begin
                        exp_valid[LAT_END+2+i] = 1;
                        exp_dat[LAT_END+2+i]   = {hi, tr_byte[i]};
                        have = 0;
                    end else begin
                        hi = tr_byte[i]; have = 1;
                    end
                end else begin
                    idle++;
                    if (idle == RD_TIMEOUT) term = i;
                end
            end
            t = LAT_END + 1 + term;
            last_low = (t % 2 == 0) ? t : t + 1;
        end
    endtask

    // Runs one transaction from its accept cycle to the last recovery cycle,
    // checking every cycle against the model.
    task automatic applyStimulus();
        int          e;
        logic        low, e_oe, e_woe;
        logic [7:0]  gotv, expv;
        buildModel();
        obs_ca = '0; obs_wdat = '0; obs_dat = '0; obs_nvalid = 0; obs_cs_low = 0;
        e = last_low + RECOVERY + 1;
        for (int c = 0; c < e; c++) begin
            @(negedge hbus_clk);
            if (c == tr_abort) begin
                hbus_rst_n = 1'b0;
                #1;
                checkOutput("reset_mid_burst", 64'({hbus_cs_n_o, hbus_busy, hbus_ck_o, hbus_dq_oe, hbus_rwds_oe, hbus_ready, hbus_dq_o}),
                            64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}));
                @(negedge hbus_clk);
                hbus_rst_n = 1'b1; hbus_rrq = 1'b0; hbus_wrq = 1'b0;
                return;
            end
            low   = (c >= 1 && c <= last_low);
            e_oe  = (c >= 1 && c <= 6) || (!tr_rd && low && c > LAT_END);
            e_woe = !tr_rd && low && c > LAT_END;
            expv  = {!low, low ? 1'((c - 1) % 2) : 1'b0, (c >= 1 && c <= last_low + RECOVERY), e_oe, e_woe, 1'b0,
                     1'(exp_ready[c]), 1'(exp_valid[c])};
            gotv  = {hbus_cs_n_o, hbus_ck_o, hbus_busy, hbus_dq_oe, hbus_rwds_oe, hbus_rwds_o, hbus_ready, hbus_valid};
            checkOutput($sformatf("ctl[cs_n ck busy dq_oe rwds_oe rwds_o ready valid] cycle %0d", c), 64'(gotv), 64'(expv));
            if (e_oe) checkOutput($sformatf("dq cycle %0d", c), 64'(hbus_dq_o), 64'(exp_dq[c]));
            if (exp_valid[c]) checkOutput($sformatf("dat_o cycle %0d", c), 64'(hbus_dat_o), 64'(exp_dat[c]));
            if (c >= 1 && c <= 6) obs_ca = {obs_ca[39:0], hbus_dq_o};
            if (c == LAT_END + 1) obs_wdat[15:8] = hbus_dq_o;
            if (c == LAT_END + 2) obs_wdat[7:0]  = hbus_dq_o;
            if (!hbus_cs_n_o) obs_cs_low++;
            if (hbus_valid) begin obs_nvalid++; obs_dat = hbus_dat_o; end
            // drive inputs for this cycle
            hbus_adr_i = (c == 0) ? tr_adr : $urandom;
            if (tr_rd) begin
                hbus_rrq = (c < LAT_END + 1 + tr_drop) && (c <= last_low);
                hbus_wrq = tr_both && hbus_rrq;
            end else begin
                hbus_rrq = 1'b0;
                hbus_wrq = (c <= LAT_END + 2*(tr_nwords - 1));
            end
            if (tr_hold && c > last_low) hbus_wrq = 1'b1;
            hbus_dat_i = 16'($urandom);
            for (int k = 0; k < tr_nwords; k++)
                if (!tr_rd && c == LAT_END + 2*k) hbus_dat_i = tr_words[k];
            if (c > LAT_END) begin
                hbus_rwds_i = tr_rwds[c-LAT_END-1];
                hbus_dq_i   = hbus_rwds_i ? tr_byte[c-LAT_END-1] : 8'($urandom);
            end else begin
                hbus_rwds_i = (c >= 7) ? 1'($urandom % 2) : 1'b0;
                hbus_dq_i   = 8'($urandom);
            end
        end
        hbus_rrq = 1'b0;
        if (!tr_hold) hbus_wrq = 1'b0;
        hbus_rwds_i = 1'b0;
    endtask

    task automatic checkIdle(input string name);
        @(negedge hbus_clk);
        checkOutput(name, 64'({hbus_cs_n_o, hbus_busy, hbus_ck_o}), 64'({1'b1, 1'b0, 1'b0}));
    endtask

    initial begin
        vecs[0] = '{rd: 1'b0, both: 1'b0, adr: 32'h00001234, data: 16'hA55A, exp_ca: 48'h2000_0246_0004};
        vecs[1] = '{rd: 1'b1, both: 1'b0, adr: 32'h00001234, data: 16'h1234, exp_ca: 48'hA000_0246_0004};
        vecs[2] = '{rd: 1'b1, both: 1'b1, adr: 32'h00001234, data: 16'hBEEF, exp_ca: 48'hA000_0246_0004};
        vecs[3] = '{rd: 1'b1, both: 1'b0, adr: 32'hFFFFFFFF, data: 16'h0001, exp_ca: 48'hBFFF_FFFF_0007};
        vecs[4] = '{rd: 1'b0, both: 1'b0, adr: 32'h80000008, data: 16'hFFFF, exp_ca: 48'h3000_0001_0000};
        vecs[5] = '{rd: 1'b0, both: 1'b0, adr: 32'h00000007, data: 16'h0000, exp_ca: 48'h2000_0000_0007};

        // reset state
        repeat (3) @(negedge hbus_clk);
        checkOutput("reset_state", 64'({hbus_cs_n_o, hbus_ck_o, hbus_busy, hbus_dq_oe, hbus_rwds_oe, hbus_rwds_o,
                                        hbus_ready, hbus_valid, hbus_dq_o, hbus_dat_o}),
                    64'({1'b1, 7'b0, 8'h00, 16'h0000}));
        hbus_rst_n = 1'b1;
        @(negedge hbus_clk);

        // directed table
        for (int v = 0; v < 6; v++) begin
            setDefaults();
            tr_rd = vecs[v].rd; tr_both = vecs[v].both; tr_adr = vecs[v].adr;
            tr_words[0] = vecs[v].data;
            if (tr_rd) begin
                tr_rwds[0] = 1'b1; tr_byte[0] = vecs[v].data[15:8];
                tr_rwds[1] = 1'b1; tr_byte[1] = vecs[v].data[7:0];
                tr_drop = 4;
            end
            applyStimulus();
            checkOutput($sformatf("table%0d_ca", v), 64'(obs_ca), 64'(vecs[v].exp_ca));
            if (tr_rd) begin
                checkOutput($sformatf("table%0d_rdata", v), 64'(obs_dat), 64'(vecs[v].data));
                checkOutput($sformatf("table%0d_nvalid", v), 64'(obs_nvalid), 64'(1));
            end else begin
                checkOutput($sformatf("table%0d_wdata", v), 64'(obs_wdat), 64'(vecs[v].data));
                checkOutput($sformatf("table%0d_cs_low", v), 64'(obs_cs_low), 64'(32));
            end
        end
        checkIdle("idle_after_table");

        // two-word write burst
        setDefaults();
        tr_rd = 1'b0; tr_adr = 32'h00000100; tr_nwords = 2;
        tr_words[0] = 16'h1111; tr_words[1] = 16'h2222;
        applyStimulus();
        checkOutput("burst2_cs_low", 64'(obs_cs_low), 64'(34));

        // read aborted after the first byte of the second word
        setDefaults();
        tr_rd = 1'b1; tr_adr = 32'h00000200;
        tr_rwds[0] = 1'b1; tr_byte[0] = 8'hAA;
        tr_rwds[1] = 1'b1; tr_byte[1] = 8'hBB;
        tr_rwds[2] = 1'b1; tr_byte[2] = 8'hCC;
        tr_drop = 3;
        applyStimulus();
        checkOutput("abort_nvalid", 64'(obs_nvalid), 64'(1));
        checkOutput("abort_rdata", 64'(obs_dat), 64'(16'hAABB));

        // request held through recovery, then a back-to-back write
        setDefaults();
        tr_rd = 1'b0; tr_adr = 32'h00000300; tr_words[0] = 16'h0F0F; tr_hold = 1'b1;
        applyStimulus();
        setDefaults();
        tr_rd = 1'b0; tr_adr = 32'h00000304; tr_words[0] = 16'hF0F0;
        applyStimulus();

        // reset in cycle 20 of a write, then a clean write
        setDefaults();
        tr_rd = 1'b0; tr_adr = 32'h00000400; tr_words[0] = 16'h5555; tr_abort = 20;
        applyStimulus();
        setDefaults();
        tr_rd = 1'b0; tr_adr = 32'h00001234; tr_words[0] = 16'hA55A;
        applyStimulus();
        checkOutput("after_reset_wdata", 64'(obs_wdat), 64'(16'hA55A));

        // read with no strobes at all ends on the timeout
        setDefaults();
        tr_rd = 1'b1; tr_adr = 32'h00000500;
        applyStimulus();
        checkOutput("timeout_cs_low", 64'(obs_cs_low), 64'(286));
        checkOutput("timeout_nvalid", 64'(obs_nvalid), 64'(0));

        // random transactions against the model
        for (int n = 0; n < 40; n++) begin
            int nb;
            setDefaults();
            tr_rd   = 1'($urandom % 2);
            tr_both = tr_rd && ($urandom % 4 == 0);
            tr_adr  = $urandom;
            if (tr_rd) begin
                nb = $urandom_range(0, 12);
                for (int i = 0; i < nb; i++) tr_rwds[i] = ($urandom % 3 != 0);
                tr_drop = ($urandom % 6 == 0) ? NEVER : $urandom_range(0, 14);
            end else begin
                tr_nwords = $urandom_range(1, 4);
                for (int k = 0; k < tr_nwords; k++) tr_words[k] = 16'($urandom);
            end
            applyStimulus();
            if ($urandom % 3 == 0) checkIdle($sformatf("idle_gap_%0d", n));
        end
        checkIdle("idle_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
